// File: rtl/ram_dp_32x8_if.sv
// Bus bundle for the 32x8 dual-port RAM: write port, read port and the
// debug copy of the whole array. The clock and reset stay outside the bundle.
interface ram_dp_32x8_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  wren;
  logic                  rden;
  logic [ADDR_WIDTH-1:0] wraddress;
  logic [ADDR_WIDTH-1:0] rdaddress;
  logic [DATA_WIDTH-1:0] data_out;
  logic [DATA_WIDTH-1:0] mem [DEPTH-1:0];

  // The FIFO control path (or a bench) drives addresses, data and enables.
  modport master (
    output data_in, wren, rden, wraddress, rdaddress,
    input  data_out, mem
  );

  // The RAM consumes the requests and returns read data and the array copy.
  modport slave (
    input  data_in, wren, rden, wraddress, rdaddress,
    output data_out, mem
  );
endinterface

// File: rtl/ram_dp_32x8.sv
// Simple dual-port synchronous RAM, 32 words x 8 bits, single clock.
// One write port and one registered read port with independent addresses.
// A read and a write to the same address on one edge return the old word
// (read-first). Synchronous active-high reset clears the array and the read
// register and overrides any concurrent read or write.
module ram_dp_32x8 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32
) (
  input logic              clock,
  input logic              reset,
  ram_dp_32x8_if.slave     bus
);

  logic [DATA_WIDTH-1:0] store [DEPTH-1:0];
  logic [DATA_WIDTH-1:0] rd_q;

  // Array update: reset clears every word, otherwise commit an enabled write.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        store[i] <= '0;
      end
    end else if (bus.wren) begin
      store[bus.wraddress] <= bus.data_in;
    end
  end

  // Read register: samples the pre-edge array contents, so same-address
  // read-during-write returns the old word; holds when rden is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q <= '0;
    end else if (bus.rden) begin
      rd_q <= store[bus.rdaddress];
    end
  end

  assign bus.data_out = rd_q;
  assign bus.mem      = store;

endmodule

// File: tb/tb_ram_dp_32x8.sv
// Directed bench for ram_dp_32x8 with an array-level reference model that is
// compared against data_out and the whole debug array on every falling edge
// once the first reset has defined the contents.
module tb_ram_dp_32x8;

  logic clock;
  logic reset;

  ram_dp_32x8_if bus ();

  ram_dp_32x8 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [7:0] ref_mem [32];
  logic [7:0] ref_out;
  bit         ref_valid = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: reset wins; otherwise a read sees the contents before this edge's write.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
      ref_out   = 8'h00;
      ref_valid = 1;
    end else begin
      if (bus.rden) ref_out = ref_mem[bus.rdaddress];
      if (bus.wren) ref_mem[bus.wraddress] = bus.data_in;
    end
  end

  // Compare process on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (ref_valid) begin
      int bad;
      checks++;
      if (bus.data_out !== ref_out) begin
        errors++;
        $display("FAIL model_data_out t=%0t got %h expected %h", $time, bus.data_out, ref_out);
      end
      checks++;
      bad = -1;
      for (int i = 0; i < 32; i++) begin
        if (bad < 0 && bus.mem[i] !== ref_mem[i]) bad = i;
      end
      if (bad >= 0) begin
        errors++;
        $display("FAIL model_mem t=%0t addr %0d got %h expected %h", $time, bad, bus.mem[bad], ref_mem[bad]);
      end
    end
  end

  task automatic check_lit(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, wait for the edge, then settle 1 time unit.
  task automatic cyc(input logic rst, input logic we, input logic [4:0] wa,
                     input logic [7:0] din, input logic re, input logic [4:0] ra);
    reset         = rst;
    bus.wren      = we;
    bus.wraddress = wa;
    bus.data_in   = din;
    bus.rden      = re;
    bus.rdaddress = ra;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int nz;
    reset         = 1'b0;
    bus.wren      = 1'b0;
    bus.rden      = 1'b0;
    bus.wraddress = '0;
    bus.rdaddress = '0;
    bus.data_in   = '0;

    // Reset after a write to addr 3.
    cyc(0, 1, 5'd3, 8'hAA, 0, 5'd0);
    check_lit("pre_reset_write_addr3", bus.mem[3], 8'hAA);
    cyc(1, 0, 5'd0, 8'h00, 0, 5'd0);
    check_lit("reset_mem3", bus.mem[3], 8'h00);
    check_lit("reset_data_out", bus.data_out, 8'h00);
    nz = 0;
    for (int i = 0; i < 32; i++) if (bus.mem[i] !== 8'h00) nz++;
    check_lit("reset_all_zero_count", 8'(nz), 8'h00);

    // Write then read, then hold with rden low.
    cyc(0, 1, 5'd7, 8'h5C, 0, 5'd0);
    check_lit("write_addr7", bus.mem[7], 8'h5C);
    check_lit("data_out_before_read", bus.data_out, 8'h00);
    cyc(0, 0, 5'd0, 8'h00, 1, 5'd7);
    check_lit("read_addr7", bus.data_out, 8'h5C);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 5'd0, 8'h00, 0, 5'd0);
      check_lit("hold_addr7", bus.data_out, 8'h5C);
    end

    // Fill all words with i+1, read back in order.
    for (int i = 0; i < 32; i++) cyc(0, 1, 5'(i), 8'(i + 1), 0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      cyc(0, 0, 5'd0, 8'h00, 1, 5'(i));
      check_lit("fill_readback", bus.data_out, 8'(i + 1));
    end
    check_lit("last_read_addr31", bus.data_out, 8'h20);
    cyc(0, 1, 5'd0, 8'hFF, 0, 5'd0);
    cyc(0, 0, 5'd0, 8'h00, 1, 5'd0);
    check_lit("wrap_read_addr0", bus.data_out, 8'hFF);
    check_lit("wrap_addr31_intact", bus.mem[31], 8'h20);

    // Simultaneous read and write at different addresses.
    cyc(0, 1, 5'd2, 8'h22, 0, 5'd0);
    cyc(0, 1, 5'd4, 8'h11, 1, 5'd2);
    check_lit("rw_diff_data_out", bus.data_out, 8'h22);
    check_lit("rw_diff_mem4", bus.mem[4], 8'h11);

    // Read-during-write to the same address returns the old word.
    cyc(0, 1, 5'd9, 8'h33, 0, 5'd0);
    cyc(0, 1, 5'd9, 8'h44, 1, 5'd9);
    check_lit("rdw_old_word", bus.data_out, 8'h33);
    check_lit("rdw_mem9_new", bus.mem[9], 8'h44);
    cyc(0, 0, 5'd0, 8'h00, 1, 5'd9);
    check_lit("rdw_next_read", bus.data_out, 8'h44);

    // Reset wins over a concurrent write and read.
    cyc(1, 1, 5'd1, 8'h77, 1, 5'd1);
    check_lit("rst_prio_mem1", bus.mem[1], 8'h00);
    check_lit("rst_prio_data_out", bus.data_out, 8'h00);
    check_lit("rst_prio_mem9", bus.mem[9], 8'h00);

    // First write after reset is accepted; read of a cleared word gives zero.
    cyc(0, 1, 5'd1, 8'h5A, 1, 5'd31);
    check_lit("post_reset_write", bus.mem[1], 8'h5A);
    check_lit("post_reset_read31", bus.data_out, 8'h00);
    cyc(0, 0, 5'd0, 8'h00, 1, 5'd1);
    check_lit("post_reset_read1", bus.data_out, 8'h5A);
    cyc(0, 0, 5'd0, 8'h00, 0, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
